// File: rtl/adc_scan_controller_pkg.sv
// Shared types and default parameters for the ADC scan controller.
package adc_scan_controller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_EOC = 3'd2,
    CS       = 3'd3,
    READ     = 3'd4,
    RELEASE  = 3'd5,
    NEXT     = 3'd6
  } scan_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CH_SEL_W    = 3;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SAMPLE_DIV  = 512;
  localparam int DEF_RD_CYC      = 2;
  localparam int DEF_EOC_TIMEOUT = 256;
  localparam int DEF_OFFSET      = 32'h60;

  // Counter width that never collapses to zero bits for a modulus of 1.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_scan_controller_if.sv
// Pin-level bundle between the scan controller and a parallel SAR ADC.
interface adc_scan_controller_if #(
  parameter int CH_SEL_W = 3,
  parameter int DATA_W   = 8
);
  logic [CH_SEL_W-1:0] chnl;
  logic                n_convst;
  logic                n_eoc;
  logic                n_cs;
  logic                n_rd;
  logic [DATA_W-1:0]   adc_in;

  modport master (
    output chnl, n_convst, n_cs, n_rd,
    input  n_eoc, adc_in
  );

  modport slave (
    input  chnl, n_convst, n_cs, n_rd,
    output n_eoc, adc_in
  );
endinterface

// File: rtl/adc_scan_controller_sample_tick_gen.sv
// Free-running divider producing a registered one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen
  import adc_scan_controller_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clk,
  input  logic n_reset,
  output logic tick
);
  localparam int               CNT_W = safe_clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Divider counter; tick is registered on the wrap.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + ONE;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;
endmodule

// File: rtl/adc_scan_controller.sv
// Multi-channel SAR ADC scan controller: converts every channel per tick, adds a fixed offset,
// and publishes the full set atomically with a one-cycle valid strobe.
module adc_scan_controller
  import adc_scan_controller_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CH_SEL_W    = DEF_CH_SEL_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int RD_CYC      = DEF_RD_CYC,
  parameter int EOC_TIMEOUT = DEF_EOC_TIMEOUT,
  parameter int OFFSET      = DEF_OFFSET
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     enable,
  input  logic                     clr_err,
  adc_scan_controller_if.master    adc,
  output logic [NUM_CH*DATA_W-1:0] samples,
  output logic                     sample_valid,
  output logic                     timeout_err,
  output logic                     overrun_err
);
  localparam int                  IDX_W     = safe_clog2(NUM_CH);
  localparam int                  WAIT_W    = safe_clog2(EOC_TIMEOUT);
  localparam int                  RD_W      = safe_clog2(RD_CYC);
  localparam logic [IDX_W-1:0]    LAST_CH   = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [WAIT_W-1:0]   LAST_WAIT = WAIT_W'(EOC_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE  = WAIT_W'(1);
  localparam logic [RD_W-1:0]     LAST_RD   = RD_W'(RD_CYC - 1);
  localparam logic [RD_W-1:0]     RD_ONE    = RD_W'(1);
  localparam logic [DATA_W-1:0]   OFFSET_C  = DATA_W'(OFFSET);

  scan_state_t                state_r;
  logic [IDX_W-1:0]           ch_idx_r;
  logic [WAIT_W-1:0]          wait_cnt_r;
  logic [RD_W-1:0]            rd_cnt_r;
  logic [CH_SEL_W-1:0]        chnl_r;
  logic                       n_convst_r;
  logic                       n_cs_r;
  logic                       n_rd_r;
  logic [DATA_W-1:0]          shadow_r [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   samples_r;
  logic                       sample_valid_r;
  logic                       timeout_err_r;
  logic                       overrun_err_r;
  logic                       tick_s;
  logic                       timeout_hit_s;
  logic                       overrun_hit_s;
  logic [IDX_W-1:0]           next_idx_s;
  logic [DATA_W-1:0]          adj_data_s;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk     (clk),
    .n_reset (n_reset),
    .tick    (tick_s)
  );

  // Error events, next channel index and the offset-corrected sample (wraps modulo 2**DATA_W).
  always_comb begin
    timeout_hit_s = (state_r == WAIT_EOC) && adc.n_eoc && (wait_cnt_r == LAST_WAIT);
    overrun_hit_s = tick_s && (state_r != IDLE);
    next_idx_s    = ch_idx_r + IDX_ONE;
    adj_data_s    = adc.adc_in + OFFSET_C;
  end

  // Scan FSM; strobes are registered so each takes effect in the state after the one that set it.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r        <= IDLE;
      ch_idx_r       <= '0;
      wait_cnt_r     <= '0;
      rd_cnt_r       <= '0;
      chnl_r         <= '0;
      n_convst_r     <= 1'b1;
      n_cs_r         <= 1'b1;
      n_rd_r         <= 1'b1;
      samples_r      <= '0;
      sample_valid_r <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_r[k] <= '0;
      end
    end else begin
      sample_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s && enable) begin
            ch_idx_r <= '0;
            chnl_r   <= '0;
            state_r  <= START;
          end else begin
            state_r  <= IDLE;
          end
        end
        START: begin
          n_convst_r <= 1'b0;
          wait_cnt_r <= '0;
          state_r    <= WAIT_EOC;
        end
        WAIT_EOC: begin
          n_convst_r <= 1'b1;
          if (!adc.n_eoc) begin
            n_cs_r  <= 1'b0;
            state_r <= CS;
          end else if (wait_cnt_r == LAST_WAIT) begin
            // Abandon the channel; its shadow keeps the previous scan's value.
            state_r <= NEXT;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        CS: begin
          n_rd_r   <= 1'b0;
          rd_cnt_r <= '0;
          state_r  <= READ;
        end
        READ: begin
          if (rd_cnt_r == LAST_RD) begin
            shadow_r[ch_idx_r] <= adj_data_s;
            n_rd_r             <= 1'b1;
            n_cs_r             <= 1'b1;
            state_r            <= RELEASE;
          end else begin
            rd_cnt_r <= rd_cnt_r + RD_ONE;
          end
        end
        RELEASE: begin
          state_r <= NEXT;
        end
        NEXT: begin
          if (ch_idx_r == LAST_CH) begin
            for (int k = 0; k < NUM_CH; k++) begin
              samples_r[k*DATA_W +: DATA_W] <= shadow_r[k];
            end
            sample_valid_r <= 1'b1;
            ch_idx_r       <= '0;
            chnl_r         <= '0;
            state_r        <= IDLE;
          end else begin
            ch_idx_r <= next_idx_s;
            chnl_r   <= CH_SEL_W'(next_idx_s);
            state_r  <= START;
          end
        end
        default: begin
          n_convst_r <= 1'b1;
          n_cs_r     <= 1'b1;
          n_rd_r     <= 1'b1;
          ch_idx_r   <= '0;
          chnl_r     <= '0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      timeout_err_r <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else if (clr_err) begin
        timeout_err_r <= 1'b0;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
      if (overrun_hit_s) begin
        overrun_err_r <= 1'b1;
      end else if (clr_err) begin
        overrun_err_r <= 1'b0;
      end else begin
        overrun_err_r <= overrun_err_r;
      end
    end
  end

  assign adc.chnl     = chnl_r;
  assign adc.n_convst = n_convst_r;
  assign adc.n_cs     = n_cs_r;
  assign adc.n_rd     = n_rd_r;
  assign samples      = samples_r;
  assign sample_valid = sample_valid_r;
  assign timeout_err  = timeout_err_r;
  assign overrun_err  = overrun_err_r;
endmodule

// File: tb/tb_adc_scan_controller.sv
// Directed bench for adc_scan_controller with a behavioural SAR ADC responder.
module tb_adc_scan_controller;
  localparam int NUM_CH      = 4;
  localparam int CH_SEL_W    = 3;
  localparam int DATA_W      = 8;
  localparam int SAMPLE_DIV  = 64;
  localparam int RD_CYC      = 2;
  localparam int EOC_TIMEOUT = 16;
  localparam int OFFSET      = 32'h60;

  logic                     clk = 1'b0;
  logic                     n_reset;
  logic                     enable;
  logic                     clr_err;
  logic [NUM_CH*DATA_W-1:0] samples;
  logic                     sample_valid;
  logic                     timeout_err;
  logic                     overrun_err;

  int checks = 0;
  int errors = 0;

  adc_scan_controller_if #(.CH_SEL_W(CH_SEL_W), .DATA_W(DATA_W)) adc ();

  adc_scan_controller #(
    .NUM_CH(NUM_CH), .CH_SEL_W(CH_SEL_W), .DATA_W(DATA_W), .SAMPLE_DIV(SAMPLE_DIV),
    .RD_CYC(RD_CYC), .EOC_TIMEOUT(EOC_TIMEOUT), .OFFSET(OFFSET)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .enable       (enable),
    .clr_err      (clr_err),
    .adc          (adc),
    .samples      (samples),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err)
  );

  always #5 clk = ~clk;

  // ADC model: n_eoc falls eoc_delay negedges after n_convst is seen low, rises on n_rd.
  int         eoc_delay = 3;
  int         dead_ch   = -1;
  logic [7:0] adc_data [4];
  int         conv_ch   = 0;
  int         eoc_cnt   = 0;
  bit         busy      = 1'b0;
  int         chnl_log [$];

  always @(negedge clk) begin
    if (!n_reset) begin
      busy      = 1'b0;
      adc.n_eoc = 1'b1;
    end else if (adc.n_convst === 1'b0) begin
      conv_ch   = int'(adc.chnl);
      eoc_cnt   = eoc_delay;
      busy      = 1'b1;
      adc.n_eoc = 1'b1;
      chnl_log.push_back(conv_ch);
    end else if (busy) begin
      eoc_cnt--;
      if (eoc_cnt <= 0) begin
        busy = 1'b0;
        if (conv_ch != dead_ch) adc.n_eoc = 1'b0;
      end
    end else if (adc.n_rd === 1'b0) begin
      adc.n_eoc = 1'b1;
    end
    adc.adc_in = adc_data[conv_ch[1:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  int  cyc;
  int  n_valid;
  int  n_conv;
  bit  found;

  initial begin
    n_reset = 1'b0;
    enable  = 1'b0;
    clr_err = 1'b0;
    adc.adc_in = '0;
    for (int k = 0; k < 4; k++) adc_data[k] = 8'h10 + 8'(k);
    repeat (3) @(negedge clk);
    check("rst_n_convst", adc.n_convst, 1'b1);
    check("rst_n_cs", adc.n_cs, 1'b1);
    check("rst_n_rd", adc.n_rd, 1'b1);
    check("rst_chnl", adc.chnl, 3'd0);
    check("rst_samples", samples, 32'h0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_overrun", overrun_err, 1'b0);

    // Basic scan: ch k returns 'h10+k, plus 'h60.
    n_reset = 1'b1;
    enable  = 1'b1;
    chnl_log.delete();
    wait_valid(200, cyc);
    check("basic_seen", cyc > 0, 1'b1);
    check("basic_samples", samples, 32'h7372_7170);
    check("chnl_log_len", chnl_log.size(), 4);
    for (int k = 0; k < 4; k++)
      check("chnl_seq", (k < chnl_log.size()) ? chnl_log[k] : -1, k);
    @(negedge clk);
    check("valid_pulse_width", sample_valid, 1'b0);
    // One negedge already consumed above, so the next pulse is SAMPLE_DIV-1 negedges away.
    wait_valid(100, cyc);
    check("valid_period", cyc, SAMPLE_DIV - 1);

    // Offset wraps: 'hB0 + 'h60 = 'h10.
    adc_data[0] = 8'hB0;
    wait_valid(100, cyc);
    check("wrap_seen", cyc > 0, 1'b1);
    check("wrap_ch0", samples[7:0], 8'h10);
    check("wrap_samples", samples, 32'h7372_7110);

    // Timeout on ch2: it keeps 'h72, the others update.
    dead_ch = 2;
    for (int k = 0; k < 4; k++) adc_data[k] = 8'h20 + 8'(k);
    wait_valid(100, cyc);
    check("to_seen", cyc > 0, 1'b1);
    check("to_samples", samples, 32'h8372_8180);
    check("to_flag", timeout_err, 1'b1);
    check("to_no_overrun", overrun_err, 1'b0);
    dead_ch = -1;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("to_cleared", timeout_err, 1'b0);

    // Overrun: 4 * 19 cycles per scan exceeds the 64-cycle tick period.
    eoc_delay = 12;
    for (int k = 0; k < 4; k++) adc_data[k] = 8'h30 + 8'(k);
    wait_valid(300, cyc);
    check("ovr_seen", cyc > 0, 1'b1);
    check("ovr_samples", samples, 32'h9392_9190);
    check("ovr_flag", overrun_err, 1'b1);
    check("ovr_no_timeout", timeout_err, 1'b0);
    eoc_delay = 3;
    wait_valid(200, cyc);
    check("ovr_next_samples", samples, 32'h9392_9190);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    wait_valid(100, cyc);
    check("ovr_cleared", overrun_err, 1'b0);

    // Drop enable while ch1 is converting: one more publish, then idle.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (adc.chnl === 3'd1 && adc.n_convst === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("en_ch1_found", found, 1'b1);
    enable  = 1'b0;
    n_valid = 0;
    n_conv  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) n_valid++;
      if (adc.n_convst === 1'b0) n_conv++;
    end
    check("en_valid_count", n_valid, 1);
    check("en_conv_count", n_conv, 2);
    check("en_samples", samples, 32'h9392_9190);

    // Asynchronous reset in the middle of READ.
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (adc.n_rd === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("rd_found", found, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    check("arst_n_rd", adc.n_rd, 1'b1);
    check("arst_n_cs", adc.n_cs, 1'b1);
    check("arst_samples", samples, 32'h0);
    check("arst_chnl", adc.chnl, 3'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
